txn_req_fifo: RTL and testbench

- Ingress stage that accepts command transactions (cmd, addr, data) from a requester over a valid/ready handshake.
- Tags each legal transaction with a sequential ID, buffers it in a DEPTH-entry FIFO, and presents it to the downstream consumer over valid/ready.
- Sits directly upstream of the transaction-processing logic and uses the shared common_pkg widths, command codes and MAX_TRANS limit.

---
 rtl/common_pkg.sv | 27 ++
 rtl/txn_req_fifo_mem.sv | 57 +++++
 rtl/txn_req_fifo.sv | 88 ++++++++
 tb/tb_txn_req_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared widths, command codes and the transaction record used across the ingress path.
package common_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned MAX_TRANS  = 1024;
  localparam int unsigned ID_WIDTH   = $clog2(MAX_TRANS);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef struct packed {
    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } txn_t;

  function automatic logic is_legal_cmd(input cmd_e cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/txn_req_fifo_mem.sv
// Generic DEPTH x WIDTH synchronous FIFO storage; occupancy is tracked by an explicit counter.
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is intentionally not reset; head contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_wr && !rst && !clr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/txn_req_fifo.sv
// Ingress FIFO: filters illegal commands, tags legal ones with a wrapping sequential ID.
module txn_req_fifo
  import common_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = common_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = common_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ID_WIDTH   = common_pkg::ID_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_cmd,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_cmd,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     cmd_err
);

  // Entry layout matches txn_t: {cmd, addr, data, id}.
  localparam int unsigned EntryW = 2 + ADDR_WIDTH + DATA_WIDTH + ID_WIDTH;

  logic                full, empty;
  logic                push, pop, cmd_legal;
  logic                wr_en, rd_en;
  logic [EntryW-1:0]   wr_entry, rd_entry;
  logic [ID_WIDTH-1:0] next_id_q;
  logic                cmd_err_q;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cmd_legal = is_legal_cmd(cmd_e'(in_cmd));

  // Flush wins over any same-cycle handshake.
  assign wr_en    = push && cmd_legal && !flush;
  assign rd_en    = pop && !flush;
  assign wr_entry = {in_cmd, in_addr, in_data, next_id_q};

  sync_fifo_mem #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      next_id_q <= '0;
    end else if (wr_en) begin
      if (next_id_q == ID_WIDTH'(MAX_TRANS - 1)) begin
        next_id_q <= '0;
      end else begin
        next_id_q <= next_id_q + ID_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= push && !cmd_legal;
    end
  end

  assign cmd_err = cmd_err_q;
  assign {out_cmd, out_addr, out_data, out_id} = rd_entry;

endmodule

// File: tb/tb_txn_req_fifo.sv
// Directed bench for txn_req_fifo with hand-computed expectations.
module tb_txn_req_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, cmd_err;
  logic [1:0]  in_cmd, out_cmd;
  logic [31:0] in_addr, out_addr;
  logic [63:0] in_data, out_data;
  logic [9:0]  out_id;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  txn_req_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (in_cmd),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cmd   (out_cmd),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_id    (out_id),
    .count     (count),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    in_valid = 1'b1;
    in_cmd   = c;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_cmd = 2'b01; in_addr = '0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cmd_err", cmd_err, 0);

    // Single READ, held while consumer stalls
    push_one(2'b01, 32'h1000, 64'h0);
    check("first_valid", out_valid, 1);
    check("first_id", out_id, 0);
    check("first_addr", out_addr, 32'h1000);
    check("first_cmd", out_cmd, 2'b01);
    check("first_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_addr", out_addr, 32'h1000);
      check("hold_id", out_id, 0);
    end

    // Fill to full with 16 WRITEs
    do_reset();
    in_cmd = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_addr = 32'h2000 + 32'(i);
      in_data = 64'(i);
      tick();
    end
    check("full_count", count, 16);
    check("full_in_ready", in_ready, 0);
    in_data = 64'd99;
    tick();
    check("full_no_push", count, 16);
    // Full with pop: still no push
    in_data = 64'd77;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("full_pop_count", count, 15);
    check("full_pop_head", out_id, 1);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("drain_data", out_data, 64'(i));
      check("drain_id", out_id, 64'(i));
      check("drain_cmd", out_cmd, 2'b10);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);
    check("drain_count", count, 0);

    // Steady stream at occupancy 4; next id is 16
    in_cmd = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stream_id", out_id, 64'(16 + i));
      check("stream_count", count, 4);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_end_count", count, 4);
    check("stream_end_head", out_id, 36);

    // Illegal command between two READs
    do_reset();
    push_one(2'b01, 32'h10, 64'h0);
    push_one(2'b11, 32'h20, 64'h0);
    check("err_pulse", cmd_err, 1);
    check("err_count", count, 1);
    push_one(2'b01, 32'h30, 64'h0);
    check("err_clear", cmd_err, 0);
    check("err_count2", count, 2);
    out_ready = 1'b1;
    check("err_id0", out_id, 0);
    check("err_addr0", out_addr, 32'h10);
    tick();
    check("err_id1", out_id, 1);
    check("err_addr1", out_addr, 32'h30);
    tick();
    out_ready = 1'b0;
    check("err_drained", count, 0);

    // ID wrap across 1025+ transactions
    do_reset();
    push_one(2'b10, 32'h0, 64'h0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      check("wrap_id", out_id, 64'(i));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("wrap_head0", out_id, 0);
    check("wrap_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push_one(2'b10, 32'h0, 64'h0);
    check("wrap_head1", out_id, 1);

    // Flush preserves the ID counter
    do_reset();
    in_cmd = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("pre_flush_count", count, 8);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    in_cmd = 2'b11;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_no_err", cmd_err, 0);
    check("flush_count2", count, 0);
    push_one(2'b01, 32'h40, 64'h0);
    check("post_flush_id", out_id, 8);
    check("post_flush_count", count, 1);

    // Reset in the middle of a burst
    in_cmd = 2'b10;
    in_valid = 1'b1;
    tick();
    tick();
    check("burst_count", count, 3);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cmd_err", cmd_err, 0);
    push_one(2'b01, 32'h50, 64'h0);
    check("mid_rst_next_id", out_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
